// File: rtl/pf_ccc_dri_initiator.sv
// DRI bus initiator: turns host request/response handshakes into one-cycle DRI
// strobes, waits for the target acknowledge with a timeout, and tracks interrupts.
//
// state  | meaning
// IDLE   | ready for a host request, DRI bus quiet
// ACCESS | one-cycle strobe with address/write/data on the DRI bus
// WAIT   | strobe dropped, address/data held, counting cycles until ack or timeout
// RESP   | response presented to the host until it is consumed
module pf_ccc_dri_initiator #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic        DRI_CLK,
    input  logic        DRI_ARST_N,
    input  logic        REQ_VALID,
    output logic        REQ_READY,
    input  logic        REQ_WRITE,
    input  logic [8:0]  REQ_ADDR,
    input  logic [31:0] REQ_WDATA,
    output logic        RSP_VALID,
    input  logic        RSP_READY,
    output logic [31:0] RSP_RDATA,
    output logic        RSP_ERR,
    output logic [10:0] DRI_CTRL,
    output logic [32:0] DRI_WDATA,
    input  logic [32:0] DRI_RDATA,
    input  logic        DRI_INTERRUPT,
    output logic        IRQ_PENDING,
    input  logic        IRQ_CLEAR
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam logic [11:0] CNT_LAST = 12'(TIMEOUT_CYCLES - 1);

    state_t      state, state_nxt;
    logic        cap_write;
    logic [8:0]  cap_addr;
    logic [31:0] cap_wdata;
    logic [11:0] wait_cnt;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        irq_prev;
    logic        irq_pending;

    logic ack;
    logic timeout;
    logic irq_rise;

    assign ack      = DRI_RDATA[32];
    assign timeout  = (wait_cnt == CNT_LAST);
    assign irq_rise = DRI_INTERRUPT & ~irq_prev;

    always_ff @(posedge DRI_CLK or negedge DRI_ARST_N) begin
        if (!DRI_ARST_N) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        REQ_READY = 1'b0;
        RSP_VALID = 1'b0;
        DRI_CTRL  = '0;
        DRI_WDATA = '0;
        case (state)
            IDLE: begin
                REQ_READY = 1'b1;
                if (REQ_VALID) state_nxt = ACCESS;
            end
            ACCESS: begin
                DRI_CTRL  = {1'b1, cap_write, cap_addr};
                DRI_WDATA = {1'b0, cap_wdata};
                state_nxt = WAIT;
            end
            WAIT: begin
                DRI_CTRL  = {1'b0, cap_write, cap_addr};
                DRI_WDATA = {1'b0, cap_wdata};
                if (ack || timeout) state_nxt = RESP;
            end
            RESP: begin
                RSP_VALID = 1'b1;
                if (RSP_READY) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Ack is checked before timeout so an ack on the last WAIT cycle still succeeds.
    always_ff @(posedge DRI_CLK or negedge DRI_ARST_N) begin
        if (!DRI_ARST_N) begin
            cap_write <= 1'b0;
            cap_addr  <= '0;
            cap_wdata <= '0;
            wait_cnt  <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (REQ_VALID) begin
                        cap_write <= REQ_WRITE;
                        cap_addr  <= REQ_ADDR;
                        cap_wdata <= REQ_WRITE ? REQ_WDATA : 32'd0;
                    end
                end
                ACCESS: wait_cnt <= '0;
                WAIT: begin
                    if (ack) begin
                        rsp_rdata <= cap_write ? 32'd0 : DRI_RDATA[31:0];
                        rsp_err   <= 1'b0;
                    end else if (timeout) begin
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 12'd1;
                    end
                end
                RESP: begin
                    if (RSP_READY) begin
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // A rising edge takes priority over a clear in the same cycle.
    always_ff @(posedge DRI_CLK or negedge DRI_ARST_N) begin
        if (!DRI_ARST_N) begin
            irq_prev    <= 1'b0;
            irq_pending <= 1'b0;
        end else begin
            irq_prev <= DRI_INTERRUPT;
            if (irq_rise) begin
                irq_pending <= 1'b1;
            end else if (IRQ_CLEAR) begin
                irq_pending <= 1'b0;
            end
        end
    end

    assign RSP_RDATA   = rsp_rdata;
    assign RSP_ERR     = rsp_err;
    assign IRQ_PENDING = irq_pending;

endmodule
